// File: rtl/amber128_mem_arb_pkg.sv
// rtl/amber128_mem_arb_pkg.sv - shared types and constants for the 128-bit memory port arbiter
package amber128_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } amber128_mem_owner_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IF,
    WAIT_DM,
    ERR_IF,
    ERR_DM
  } amber128_mem_arb_state_e;

  localparam logic [63:0] AMBER128_MEM_ALIGN_MASK = 64'hF;

  function automatic logic amber128_mem_misaligned(input logic [63:0] addr);
    return (addr & AMBER128_MEM_ALIGN_MASK) != 64'd0;
  endfunction

endpackage

// File: rtl/amber128_mem_arb_if.sv
// rtl/amber128_mem_arb_if.sv - fetch, data and memory handshake bundle of the arbiter
interface amber128_mem_arb_if;
  logic         if_req_i;
  logic [63:0]  if_addr_i;
  logic         if_gnt_o;
  logic         if_rvalid_o;
  logic [127:0] if_rdata_o;
  logic         if_err_o;
  logic         dm_req_i;
  logic         dm_we_i;
  logic [63:0]  dm_addr_i;
  logic [127:0] dm_wdata_i;
  logic         dm_gnt_o;
  logic         dm_rvalid_o;
  logic         dm_err_o;
  logic [127:0] dm_rdata_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [63:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic         mem_err_i;
  logic [127:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output dm_gnt_o, dm_rvalid_o, dm_err_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_err_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  dm_gnt_o, dm_rvalid_o, dm_err_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/amber128_mem_arb_pick.sv
// rtl/amber128_mem_arb_pick.sv - winner selection: lock holder, else data unless fetch is starved
module amber128_mem_arb_pick
  import amber128_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                if_req,
  input  logic                dm_req,
  input  logic [CNT_W-1:0]    starve_cnt,
  input  amber128_mem_owner_e lock_owner,
  output amber128_mem_owner_e winner
);

  always_comb begin
    winner = OWN_NONE;
    if (lock_owner != OWN_NONE) begin
      winner = lock_owner;
    end else if (dm_req && !(if_req && starve_cnt == CNT_W'(STARVE_LIMIT))) begin
      winner = OWN_DM;
    end else if (if_req) begin
      winner = OWN_IF;
    end
  end

endmodule

// File: rtl/amber128_mem_arb.sv
// rtl/amber128_mem_arb.sv - one-outstanding arbiter sharing the 128-bit memory port between fetch and data
module amber128_mem_arb
  import amber128_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  amber128_mem_arb_if.slave  bus
);

  amber128_mem_arb_state_e state, state_nxt;
  amber128_mem_owner_e     lock_owner, lock_nxt, winner;
  logic [CNT_W-1:0]        starve_cnt, starve_nxt;
  logic [63:0]             win_addr;
  logic                    win_bad;
  logic                    granted;

  amber128_mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_pick (
    .if_req     (bus.if_req_i),
    .dm_req     (bus.dm_req_i),
    .starve_cnt (starve_cnt),
    .lock_owner (lock_owner),
    .winner     (winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lock_owner <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign win_addr = (winner == OWN_DM) ? bus.dm_addr_i : bus.if_addr_i;
  assign win_bad  = amber128_mem_misaligned(win_addr);

  // Outputs are held at 0 while rst is high so the reset state is visible immediately.
  always_comb begin
    state_nxt       = state;
    lock_nxt        = lock_owner;
    starve_nxt      = starve_cnt;
    granted         = 1'b0;
    bus.if_gnt_o    = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.if_err_o    = 1'b0;
    bus.if_rdata_o  = '0;
    bus.dm_gnt_o    = 1'b0;
    bus.dm_rvalid_o = 1'b0;
    bus.dm_err_o    = 1'b0;
    bus.dm_rdata_o  = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (winner != OWN_NONE) begin
            if (win_bad) begin
              granted   = 1'b1;
              lock_nxt  = OWN_NONE;
              state_nxt = (winner == OWN_DM) ? ERR_DM : ERR_IF;
            end else begin
              bus.mem_req_o   = 1'b1;
              bus.mem_addr_o  = win_addr;
              bus.mem_we_o    = (winner == OWN_DM) && bus.dm_we_i;
              bus.mem_wdata_o = (winner == OWN_DM) ? bus.dm_wdata_i : '0;
              granted         = bus.mem_gnt_i;
              if (bus.mem_gnt_i) begin
                lock_nxt  = OWN_NONE;
                state_nxt = (winner == OWN_DM) ? WAIT_DM : WAIT_IF;
              end else begin
                lock_nxt  = winner;
              end
            end
            bus.if_gnt_o = granted && (winner == OWN_IF);
            bus.dm_gnt_o = granted && (winner == OWN_DM);
            // Consecutive data grants only count while fetch is actually waiting.
            if (granted) begin
              if (winner == OWN_IF || !bus.if_req_i) begin
                starve_nxt = '0;
              end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_nxt = starve_cnt + CNT_W'(1);
              end
            end
          end
        end
        WAIT_IF: begin
          if (bus.mem_rvalid_i) begin
            bus.if_rvalid_o = 1'b1;
            bus.if_err_o    = bus.mem_err_i;
            bus.if_rdata_o  = bus.mem_rdata_i;
            state_nxt       = IDLE;
          end
        end
        WAIT_DM: begin
          if (bus.mem_rvalid_i) begin
            bus.dm_rvalid_o = 1'b1;
            bus.dm_err_o    = bus.mem_err_i;
            bus.dm_rdata_o  = bus.mem_rdata_i;
            state_nxt       = IDLE;
          end
        end
        ERR_IF: begin
          bus.if_rvalid_o = 1'b1;
          bus.if_err_o    = 1'b1;
          state_nxt       = IDLE;
        end
        ERR_DM: begin
          bus.dm_rvalid_o = 1'b1;
          bus.dm_err_o    = 1'b1;
          state_nxt       = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/amber128_mem_arb.md
# amber128_mem_arb

Arbiter and sequencer that shares the single 128-bit memory port between the instruction-fetch requester (16-byte bundle fetch) and the data requester (`ld128`/`st128`). It sits between the fetch/execute stages and the memory system. It keeps exactly one transaction outstanding, gives data priority with a bounded starvation guard for fetch, and rejects misaligned addresses locally with an error response.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive data grants allowed while fetch waits; the next grant then goes to fetch.
- `CNT_W`, default `$clog2(STARVE_LIMIT+1)`: width of the starvation counter.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req_i`  in  1  fetch request; held with its address until `if_gnt_o`.
- `if_addr_i`  in  64  fetch byte address; must be 16-byte aligned.
- `if_gnt_o`  out  1  fetch request accepted this cycle.
- `if_rvalid_o`  out  1  fetch response valid (one-cycle pulse).
- `if_rdata_o`  out  128  fetch bundle.
- `if_err_o`  out  1  fetch error; qualified by `if_rvalid_o`.
- `dm_req_i`, `dm_we_i`  in  1 each  data request and write enable; both held until `dm_gnt_o`.
- `dm_addr_i`  in  64  data byte address; must be 16-byte aligned.
- `dm_wdata_i`  in  128  store data.
- `dm_gnt_o`, `dm_rvalid_o`, `dm_err_o`  out  1 each  same meaning as the fetch-side signals.
- `dm_rdata_o`  out  128  load data.
- `mem_req_o`, `mem_we_o`  out  1 each  memory request.
- `mem_addr_o`  out  64  memory byte address.
- `mem_wdata_o`  out  128  memory write data.
- `mem_gnt_i`  in  1  memory accepted the request.
- `mem_rvalid_i`, `mem_err_i`  in  1 each  memory response and error; a store also returns one `mem_rvalid_i` as its acknowledge.
- `mem_rdata_i`  in  128  memory read data.

## Operation
- States:
  - `IDLE`: no transaction outstanding.
  - `WAIT_IF`, `WAIT_DM`: a memory response is owed to the named requester.
  - `ERR_IF`, `ERR_DM`: a local misalignment error response is pending.
- Pick rule in `IDLE`:
  - The winner is `dm` if `dm_req_i` is high, except when `if_req_i` is high and `starve_cnt == STARVE_LIMIT`; then the winner is `if`.
  - With only one request high, that requester wins.
- Lock: once `mem_req_o` is asserted without `mem_gnt_i`, the winner is registered in `lock_owner`. The memory request stays with that requester until granted, even if the other requester raises its request.
- Aligned winner:
  - `mem_req_o`, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven combinationally from the winner. `mem_we_o` is 0 for fetch.
  - Winner's `gnt = mem_gnt_i`. On the grant, the FSM moves to `WAIT_IF` or `WAIT_DM`.
- Misaligned winner (`addr[3:0] != 0`):
  - `mem_req_o` stays 0 and the winner's `gnt` is asserted immediately.
  - The FSM moves to `ERR_*`. In `ERR_*` the block drives `rvalid=1`, `err=1`, `rdata=0` to that requester, then returns to `IDLE`.
- In `WAIT_*`:
  - On `mem_rvalid_i`, `rvalid`, `err` and `rdata` are routed to the owner in the same cycle, and the FSM goes to `IDLE`.
  - No new request is issued in a `WAIT_*` cycle, including the response cycle.
- Starvation counter `starve_cnt` (`CNT_W` bits):
  - Increments, saturating at `STARVE_LIMIT`, on each `dm` grant while `if_req_i` is high.
  - Clears on any `if` grant, and on a `dm` grant while `if_req_i` is low.
- `mem_rvalid_i` in `IDLE` or `ERR_*` is ignored.
- The non-owner's `rvalid`, `err` and `rdata` outputs are 0.

## Timing
- Reset values: every output 0; state `IDLE`; `starve_cnt=0`; `lock_owner` cleared.
- Reset mid-transaction aborts the transaction. A late `mem_rvalid_i` after reset is ignored.
- Request to `mem_req_o`: 0 cycles, combinational in `IDLE`.
- `gnt` to `rvalid`: at least 1 cycle. The memory's response latency is passed through with no extra registering.
- Misaligned request: `gnt` in cycle N, error response in cycle N+1, next grant possible in cycle N+2.
- Aligned throughput: at most one transaction per (memory latency + 1) cycles.
- If both requests rise in the same cycle with `starve_cnt < STARVE_LIMIT`, `dm` wins.

## Structure
- Add to the shared package:
  - `amber128_mem_owner_e` with values `OWN_NONE`, `OWN_IF`, `OWN_DM`.
  - `amber128_mem_arb_state_e`.
  - `AMBER128_MEM_ALIGN_MASK = 64'hF`.
- One natural sub-module: `amber128_mem_arb_pick`. It is the combinational winner selection from (`if_req`, `dm_req`, `starve_cnt`, `lock_owner`) and returns `amber128_mem_owner_e`.

## Test plan
- Single fetch: `if_addr=0x40`, memory grants immediately and responds 3 cycles later with `0xA5..A5` → `if_gnt` in cycle 0, `if_rvalid` with `if_rdata=0xA5..A5` in cycle 3, `mem_we_o=0`.
- Simultaneous fetch and data requests, `STARVE_LIMIT=4`, `dm_req` held continuously → grant order `dm`, `dm`, `dm`, `dm`, `if`, then `starve_cnt` returns to 0.
- Misaligned store to `0x1008` → no `mem_req_o`; `dm_gnt` in cycle N; `dm_rvalid=1`, `dm_err=1`, `dm_rdata=0` in cycle N+1.
- Memory stalls `mem_gnt_i=0` for 5 cycles on a fetch while `dm_req` rises in cycle 2 → `mem_addr_o` stays at the fetch address throughout, and the fetch is granted first.
- Store with `mem_err_i=1` in its response → `dm_rvalid=1` and `dm_err=1` for one cycle; fetch side stays 0.
- `rst` asserted in `WAIT_DM`, then `mem_rvalid_i` 2 cycles later → all outputs 0, no `dm_rvalid_o`, state `IDLE`.
